// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one PMEM port between IFU and LSU, one transaction at a time.
// Define ARB_RR_EN for round-robin tie-break; default is fixed LSU priority.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rsp_valid,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [MW-1:0] lsu_wmask,
    output logic          lsu_rsp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_wmask,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          mreq_q;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic [DW-1:0] rdata_q;
    logic          ifu_rsp_q;
    logic          lsu_rsp_q;
    logic          grant_ifu;
    logic          grant_lsu;
    logic          idle;

    assign idle = (state_q == IDLE);

`ifdef ARB_RR_EN
    logic last_q;

    // Round-robin: on a tie the requester not served last time wins.
    always_comb begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = ~last_q;
            grant_ifu = last_q;
        end
    end

    // Remember who won the most recent grant (1 = LSU).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else if (idle && (grant_ifu || grant_lsu)) begin
            last_q <= grant_lsu;
        end
    end
`else
    assign grant_lsu = lsu_req_valid;
    assign grant_ifu = ifu_req_valid & ~lsu_req_valid;
`endif

    assign ifu_req_ready = rst_n & idle & grant_ifu;
    assign lsu_req_ready = rst_n & idle & grant_lsu;

    assign mem_req_valid = mreq_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rsp_valid = ifu_rsp_q;
    assign lsu_rsp_valid = lsu_rsp_q;
    assign ifu_rdata     = rdata_q;
    assign lsu_rdata     = rdata_q;

    // Transaction FSM: grant, issue, wait for completion, return response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            mreq_q    <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            ifu_rsp_q <= 1'b0;
            lsu_rsp_q <= 1'b0;
        end else begin
            ifu_rsp_q <= 1'b0;
            lsu_rsp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_lsu) begin
                        owner_q <= 1'b1;
                        addr_q  <= lsu_addr;
                        wen_q   <= lsu_wen;
                        wdata_q <= lsu_wdata;
                        wmask_q <= lsu_wmask;
                        mreq_q  <= 1'b1;
                        state_q <= REQ;
                    end else if (grant_ifu) begin
                        owner_q <= 1'b0;
                        addr_q  <= ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        mreq_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mreq_q  <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q   <= mem_rdata;
                        ifu_rsp_q <= ~owner_q;
                        lsu_rsp_q <= owner_q;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared PMEM port of the multi-cycle NPC core between the instruction-fetch requester (IFU) and the load/store requester (LSU). Each requester presents a valid/ready request (address, write enable, write data, byte mask); the arbiter grants one requester, drives the request to memory, waits for the memory response and returns it to the granted requester only. It replaces the direct combinational PMEM access used by the single-cycle core.

## Interface
- AW, 32, address width
- DW, 32, data width
- MW, 8, mask width (same encoding as the control unit's op_PMEM)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid / lsu_req_valid  in  1  requester has a request pending
- ifu_req_ready / lsu_req_ready  out  1  request accepted this cycle
- ifu_addr / lsu_addr  in  AW  request address
- lsu_wen  in  1  1 = store, 0 = load (IFU is always read)
- lsu_wdata  in  DW  store data
- lsu_wmask  in  MW  byte mask
- ifu_rsp_valid / lsu_rsp_valid  out  1  one-cycle response strobe
- ifu_rdata / lsu_rdata  out  DW  response data, valid with rsp_valid
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW
- mem_wen  out  1
- mem_wdata  out  DW
- mem_wmask  out  MW  0 for reads
- mem_rsp_valid  in  1  memory completes the current request (reads and writes)
- mem_rdata  in  DW

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any req_valid, pick the winner; assert the winner's req_ready for exactly this cycle; latch addr/wen/wdata/wmask and the owner id; go to REQ. IFU requests latch wen=0, wdata=0, wmask=0.
- Fixed priority: LSU wins over IFU when both are valid.
- REQ: mem_req_valid=1 with the latched fields. On mem_req_ready=1, go to WAIT. Otherwise hold all fields stable.
- WAIT: on mem_rsp_valid=1, latch mem_rdata and go to RESP.
- RESP: assert owner's rsp_valid for one cycle with the latched data; the other requester's rsp_valid stays 0; go to IDLE.
- Writes also complete through mem_rsp_valid. The rdata returned for a write is whatever memory returned, and requesters ignore it.
- Requesters hold a request stable until they see req_ready. req_valid dropping before acceptance is legal, and the request is then not granted.
- mem_rsp_valid outside WAIT is ignored.
- mem_req_ready outside REQ is ignored.
- Only one transaction is outstanding at a time. req_ready is never asserted outside IDLE.

## Timing
- Reset: all outputs 0, state IDLE, owner = IFU, latched registers 0. Reset applies asynchronously, including mid-transaction. The in-flight transaction is abandoned and no rsp_valid is emitted.
- Request accepted in cycle t (IDLE) gives REQ in t+1.
- With mem_req_ready=1 in t+1, WAIT is in t+2.
- With mem_rsp_valid=1 in t+2, rsp_valid is in t+3.
- Minimum request-to-response latency is 3 cycles. Maximum throughput is one transaction per 4 cycles.
- Each cycle of memory backpressure in REQ, or each cycle of missing response in WAIT, adds one cycle of latency.
- rsp_valid and rdata are registered outputs. req_ready is combinational from req_valid and state.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. When both requesters are valid in IDLE, the one not granted last time wins. A single valid requester always wins. The last-grant register resets to IFU, so LSU wins the first tie.
- ARB_RR_EN undefined: fixed LSU priority as in Operation. The last-grant register is not built.

## Test plan
- IFU-only read: ifu_addr=0x80000000, memory ready immediately, rdata=0x00000413 one cycle later -> ifu_req_ready at t, mem_req_valid at t+1, ifu_rsp_valid=1 with 0x00000413 at t+3, lsu_rsp_valid stays 0.
- LSU store: lsu_addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> mem_wen=1, mem_wmask=0x0F, and mem fields stable through 3 cycles with mem_req_ready=0 -> lsu_rsp_valid at t+6.
- Simultaneous IFU and LSU requests in IDLE, fixed priority -> LSU granted first and IFU granted on the next IDLE. With ARB_RR_EN and three back-to-back ties -> grants LSU, IFU, LSU.
- Memory response delayed 5 cycles in WAIT -> FSM stays in WAIT, no rsp_valid, req_ready held 0 despite pending IFU request.
- rst_n pulled low during WAIT -> all outputs 0 immediately. After release, a stray mem_rsp_valid is ignored and the next request follows the 3-cycle latency.
- Stray mem_rsp_valid=1 in IDLE with no requests -> no rsp_valid on either side and state stays IDLE.
